// File: rtl/mips_pkg.sv
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared loader state encoding, MIPS opcodes and instruction types.
// Options  : CHECKSUM_EN adds the CHK loader state
// Revision : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_LOAD = 3'd2,
`ifdef CHECKSUM_EN
        S_CHK  = 3'd3,
`endif
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } loader_state_t;

    typedef enum logic [2:0] {
        RR_ALU = 3'd0,
        RM_ALU = 3'd1,
        LOAD   = 3'd2,
        STORE  = 3'd3,
        BRANCH = 3'd4,
        HALT   = 3'd5
    } instr_type_t;

    localparam logic [5:0] c_OP_ADD   = 6'b000000;
    localparam logic [5:0] c_OP_SUB   = 6'b000001;
    localparam logic [5:0] c_OP_AND   = 6'b000010;
    localparam logic [5:0] c_OP_OR    = 6'b000011;
    localparam logic [5:0] c_OP_SLT   = 6'b000100;
    localparam logic [5:0] c_OP_MUL   = 6'b000101;
    localparam logic [5:0] c_OP_LW    = 6'b001000;
    localparam logic [5:0] c_OP_SW    = 6'b001001;
    localparam logic [5:0] c_OP_ADDI  = 6'b001010;
    localparam logic [5:0] c_OP_SUBI  = 6'b001011;
    localparam logic [5:0] c_OP_SLTI  = 6'b001100;
    localparam logic [5:0] c_OP_BNEQZ = 6'b001101;
    localparam logic [5:0] c_OP_BEQZ  = 6'b001110;
    localparam logic [5:0] c_OP_HLT   = 6'b111111;

    // Unknown opcodes are treated as HALT so a corrupt image stops the core.
    function automatic instr_type_t op_type(input logic [5:0] op);
        instr_type_t t;
        t = HALT;
        case (op)
            c_OP_ADD, c_OP_SUB, c_OP_AND,
            c_OP_OR, c_OP_SLT, c_OP_MUL:     t = RR_ALU;
            c_OP_ADDI, c_OP_SUBI, c_OP_SLTI: t = RM_ALU;
            c_OP_LW:                         t = LOAD;
            c_OP_SW:                         t = STORE;
            c_OP_BNEQZ, c_OP_BEQZ:           t = BRANCH;
            default:                         t = HALT;
        endcase
        return t;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_byte_packer.sv
// ============================================================================
// Module   : mips_byte_packer
// Brief    : Assembles accepted bytes big-endian into 32-bit words.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mips_byte_packer (
    input  logic        clk1,
    input  logic        rst,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic [31:0] o_word,
    output logic        o_word_valid,
    output logic        o_last_byte
);

    logic [1:0]  r_cnt;
    logic [31:0] r_word;
    logic        r_word_valid;

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_cnt        <= 2'd0;
            r_word       <= 32'd0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_byte_valid) begin
                r_word <= {r_word[23:0], i_byte};
                r_cnt  <= r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    r_word_valid <= 1'b1;
                end
            end
        end
    end

    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;
    assign o_last_byte  = (r_cnt == 2'd3);

endmodule

`default_nettype wire

// File: rtl/mips_prog_loader.sv
// ============================================================================
// Module   : mips_prog_loader
// Brief    : Streams a length-prefixed program into instruction memory.
// Options  : CHECKSUM_EN enables an XOR trailer-word check before run
// Revision : 1.0
// ============================================================================
`default_nettype none

module mips_prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    import mips_pkg::*;

    localparam logic [ADDR_W-1:0] c_BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [32:0]       c_MAX_N = 33'd1 << ADDR_W;

    loader_state_t     r_state;
    logic              r_in_ready;
    logic              r_busy;
    logic              r_cpu_run;
    logic              r_error;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   r_words;
`ifdef CHECKSUM_EN
    logic [31:0]       r_xor;
`endif

    logic              w_accept;
    logic              w_accept_last;
    logic              w_last_byte;
    logic [31:0]       w_word;
    logic              w_word_valid;
    logic              w_n_bad;
    logic [ADDR_W:0]   w_words_inc;

    mips_byte_packer u_packer (
        .clk1         (clk1),
        .rst          (rst),
        .i_byte       (in_data),
        .i_byte_valid (w_accept),
        .o_word       (w_word),
        .o_word_valid (w_word_valid),
        .o_last_byte  (w_last_byte)
    );

    assign w_accept      = in_valid & r_in_ready;
    assign w_accept_last = w_accept & w_last_byte;
    assign w_n_bad       = (w_word == 32'd0) || ({1'b0, w_word} > c_MAX_N);
    assign w_words_inc   = r_words + (ADDR_W + 1)'(1);

    // in_ready drops for the cycle after every 4th byte, so each completed
    // word is consumed by the FSM with no byte transfer in flight.
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_cpu_run  <= 1'b0;
            r_error    <= 1'b0;
            r_addr     <= '0;
            r_count    <= '0;
            r_words    <= '0;
`ifdef CHECKSUM_EN
            r_xor      <= 32'd0;
`endif
        end else begin
            if (w_accept_last) begin
                r_in_ready <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_HDR;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_addr     <= c_BASE;
                    end
                end
                S_HDR: begin
                    if (w_word_valid) begin
                        if (w_n_bad) begin
                            r_state <= S_ERR;
                            r_busy  <= 1'b0;
                            r_error <= 1'b1;
                        end else begin
                            r_state    <= S_LOAD;
                            r_count    <= w_word[ADDR_W:0];
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_word_valid) begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_words <= w_words_inc;
`ifdef CHECKSUM_EN
                        r_xor   <= r_xor ^ w_word;
`endif
                        if (w_words_inc == r_count) begin
`ifdef CHECKSUM_EN
                            r_state    <= S_CHK;
                            r_in_ready <= 1'b1;
`else
                            r_state   <= S_DONE;
                            r_busy    <= 1'b0;
                            r_cpu_run <= 1'b1;
`endif
                        end else begin
                            r_in_ready <= 1'b1;
                        end
                    end
                end
`ifdef CHECKSUM_EN
                S_CHK: begin
                    if (w_word_valid) begin
                        r_busy <= 1'b0;
                        if (w_word == r_xor) begin
                            r_state   <= S_DONE;
                            r_cpu_run <= 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    // DONE and ERR hold until reset
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign mem_we       = w_word_valid && (r_state == S_LOAD);
    assign mem_addr     = r_addr;
    assign mem_wdata    = w_word;
    assign cpu_run      = r_cpu_run;
    assign busy         = r_busy;
    assign error        = r_error;
    assign words_loaded = r_words;

endmodule

`default_nettype wire

// File: tb/tb_mips_prog_loader.sv
// ============================================================================
// Module   : tb_mips_prog_loader
// Brief    : Table-driven bench for mips_prog_loader at BASE_ADDR 0 and 1022.
// Options  : CHECKSUM_EN sends trailer words and expects the trailer check
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mips_prog_loader;

    logic        clk1 = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;

    logic        in_ready_a, mem_we_a, cpu_run_a, busy_a, error_a;
    logic [9:0]  mem_addr_a;
    logic [31:0] mem_wdata_a;
    logic [10:0] words_loaded_a;
    logic        in_ready_b, mem_we_b, cpu_run_b, busy_b, error_b;
    logic [9:0]  mem_addr_b;
    logic [31:0] mem_wdata_b;
    logic [10:0] words_loaded_b;

    always #5 clk1 = ~clk1;

    mips_prog_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut_a (
        .clk1(clk1), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .cpu_run(cpu_run_a), .busy(busy_a),
        .error(error_a), .words_loaded(words_loaded_a)
    );

    mips_prog_loader #(.ADDR_W(10), .BASE_ADDR(1022)) dut_b (
        .clk1(clk1), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .cpu_run(cpu_run_b), .busy(busy_b),
        .error(error_b), .words_loaded(words_loaded_b)
    );

    // Observed writes; the main process reads them through rd_a / rd_b.
    logic [41:0] act_a[$];
    logic [41:0] act_b[$];
    int          overlap = 0;

    always @(negedge clk1) begin
        if (mem_we_a) act_a.push_back({mem_addr_a, mem_wdata_a});
        if (mem_we_b) act_b.push_back({mem_addr_b, mem_wdata_b});
        if ((mem_we_a && in_ready_a) || (mem_we_b && in_ready_b)) overlap++;
    end

    typedef struct {
        logic [31:0]      hdr;
        int               nw;
        logic [0:3][31:0] w;
        bit               gap;
        bit               bad_trl;
        bit               exp_run;
        bit               exp_err;
        bit               exp_busy;
        int               exp_wl;
    } vec_t;

    vec_t        vecs[9];
    logic [41:0] qa[$];
    logic [41:0] qb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          rd_a = 0;
    int          rd_b = 0;

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk1);
        rst = 1'b1;
        @(negedge clk1);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk1);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        t = 0;
        if (gap) begin
            in_valid = 1'b0;
            @(negedge clk1);
        end
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready_a && t < 40) begin
            @(negedge clk1);
            t++;
        end
        if (!in_ready_a) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_ready_timeout: in_ready=0 after %0d cycles, want 1", t);
        end
        @(negedge clk1);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], gap);
    endtask

    task automatic compare_writes(input int idx);
        check("write_count_a", idx, act_a.size() - rd_a, qa.size());
        check("write_count_b", idx, act_b.size() - rd_b, qb.size());
        while (qa.size() > 0 && rd_a < act_a.size()) begin
            check("write_a", idx, act_a[rd_a], qa.pop_front());
            rd_a++;
        end
        while (qb.size() > 0 && rd_b < act_b.size()) begin
            check("write_b", idx, act_b[rd_b], qb.pop_front());
            rd_b++;
        end
        qa.delete();
        qb.delete();
        rd_a = act_a.size();
        rd_b = act_b.size();
    endtask

    initial begin
        vec_t        v;
        logic [31:0] x;

        vecs[0] = '{hdr: 32'd2, nw: 2, w: {32'h2801000A, 32'hFC000000, 32'h0, 32'h0}, gap: 1'b0, bad_trl: 1'b0, exp_run: 1'b1, exp_err: 1'b0, exp_busy: 1'b0, exp_wl: 2};
        vecs[1] = '{hdr: 32'd0, nw: 0, w: {32'h0, 32'h0, 32'h0, 32'h0}, gap: 1'b0, bad_trl: 1'b0, exp_run: 1'b0, exp_err: 1'b1, exp_busy: 1'b0, exp_wl: 0};
        vecs[2] = '{hdr: 32'd3, nw: 3, w: {32'h11111111, 32'h22222222, 32'h33333333, 32'h0}, gap: 1'b0, bad_trl: 1'b0, exp_run: 1'b1, exp_err: 1'b0, exp_busy: 1'b0, exp_wl: 3};
        vecs[3] = '{hdr: 32'd1, nw: 1, w: {32'h12345678, 32'h0, 32'h0, 32'h0}, gap: 1'b1, bad_trl: 1'b0, exp_run: 1'b1, exp_err: 1'b0, exp_busy: 1'b0, exp_wl: 1};
        vecs[4] = '{hdr: 32'd2, nw: 2, w: {32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0, 32'h0}, gap: 1'b0, bad_trl: 1'b0, exp_run: 1'b1, exp_err: 1'b0, exp_busy: 1'b0, exp_wl: 2};
`ifdef CHECKSUM_EN
        vecs[5] = '{hdr: 32'd2, nw: 2, w: {32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0, 32'h0}, gap: 1'b0, bad_trl: 1'b1, exp_run: 1'b0, exp_err: 1'b1, exp_busy: 1'b0, exp_wl: 2};
`else
        vecs[5] = '{hdr: 32'd2, nw: 2, w: {32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0, 32'h0}, gap: 1'b0, bad_trl: 1'b1, exp_run: 1'b1, exp_err: 1'b0, exp_busy: 1'b0, exp_wl: 2};
`endif
        vecs[6] = '{hdr: 32'd1025, nw: 0, w: {32'h0, 32'h0, 32'h0, 32'h0}, gap: 1'b0, bad_trl: 1'b0, exp_run: 1'b0, exp_err: 1'b1, exp_busy: 1'b0, exp_wl: 0};
        vecs[7] = '{hdr: 32'd1024, nw: 0, w: {32'h0, 32'h0, 32'h0, 32'h0}, gap: 1'b0, bad_trl: 1'b0, exp_run: 1'b0, exp_err: 1'b0, exp_busy: 1'b1, exp_wl: 0};
        vecs[8] = '{hdr: 32'h80000001, nw: 0, w: {32'h0, 32'h0, 32'h0, 32'h0}, gap: 1'b0, bad_trl: 1'b0, exp_run: 1'b0, exp_err: 1'b1, exp_busy: 1'b0, exp_wl: 0};

        do_reset();
        check("reset_outputs_a", 0, {mem_we_a, mem_addr_a, mem_wdata_a, cpu_run_a, busy_a, error_a, in_ready_a, words_loaded_a}, 64'd0);
        check("reset_outputs_b", 0, {mem_we_b, mem_addr_b, mem_wdata_b, cpu_run_b, busy_b, error_b, in_ready_b, words_loaded_b}, 64'd0);

        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            do_reset();
            pulse_start();
            send_word(v.hdr, v.gap);
            x = 32'd0;
            for (int j = 0; j < v.nw; j++) begin
                qa.push_back({10'(j), v.w[j]});
                qb.push_back({10'(1022 + j), v.w[j]});
                x = x ^ v.w[j];
                send_word(v.w[j], v.gap);
            end
`ifdef CHECKSUM_EN
            if (v.nw > 0 && v.nw == int'(v.hdr)) send_word(v.bad_trl ? ~x : x, v.gap);
`endif
            repeat (4) @(negedge clk1);
            check("cpu_run", i, cpu_run_a, v.exp_run);
            check("error", i, error_a, v.exp_err);
            check("busy", i, busy_a, v.exp_busy);
            check("in_ready", i, in_ready_a, v.exp_busy);
            check("words_loaded", i, words_loaded_a, v.exp_wl);
            check("cpu_run_b", i, cpu_run_b, v.exp_run);
            compare_writes(i);
        end

        // Reset after 6 bytes of an N=4 load, with start and in_valid also high.
        do_reset();
        pulse_start();
        send_word(32'd4, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        rst = 1'b1;
        start = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hCC;
        @(negedge clk1);
        rst = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        @(negedge clk1);
        check("midrst_outputs", 9, {cpu_run_a, busy_a, error_a, in_ready_a, words_loaded_a}, 64'd0);
        compare_writes(9);

        pulse_start();
        send_word(32'd1, 1'b0);
        qa.push_back({10'd0, 32'hCAFEF00D});
        qb.push_back({10'd1022, 32'hCAFEF00D});
        send_word(32'hCAFEF00D, 1'b0);
`ifdef CHECKSUM_EN
        send_word(32'hCAFEF00D, 1'b0);
`endif
        repeat (4) @(negedge clk1);
        check("reload_run", 10, {cpu_run_a, busy_a, error_a, words_loaded_a}, {3'b100, 11'd1});
        compare_writes(10);

        // DONE ignores a further start.
        pulse_start();
        repeat (3) @(negedge clk1);
        check("done_sticky", 11, {cpu_run_a, busy_a, in_ready_a}, 3'b100);
        check("accept_write_overlap", 11, overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/mips_prog_loader.md
MIPS_PROG_LOADER -- requirements
Module: mips_prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address width of the target 1024 x 32 memory.
REQ-002 SHALL have parameter BASE_ADDR, default 0, meaning first memory word written.
REQ-003 SHALL have port clk1  input  1  sole clock; all logic on posedge clk1.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a load.
REQ-006 SHALL have port in_data  input  8  program byte stream.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_ready  output  1  loader accepts a byte; transfer occurs when in_valid and in_ready are both high.
REQ-009 SHALL have port mem_we  output  1  one-cycle memory write strobe.
REQ-010 SHALL have port mem_addr  output  ADDR_W  memory word address.
REQ-011 SHALL have port mem_wdata  output  32  memory write word.
REQ-012 SHALL have port cpu_run  output  1  high once the program is loaded; drives the pipeline's run/not-halted enable.
REQ-013 SHALL have port busy  output  1  load in progress.
REQ-014 SHALL have port error  output  1  load aborted.
REQ-015 SHALL have port words_loaded  output  ADDR_W+1  count of words written.

Function
REQ-016 SHALL implement states IDLE, HDR, LOAD, CHK, DONE, ERR.
REQ-017 IDLE -> HDR on start; start SHALL be ignored in every other state.
REQ-018 Bytes SHALL assemble big-endian: first accepted byte becomes bits [31:24].
REQ-019 HDR: the first 4-byte word SHALL be word count N; N = 0 or N > 2^ADDR_W -> ERR, else -> LOAD.
REQ-020 LOAD: each completed word SHALL produce mem_we high for exactly one cycle, in the cycle after the 4th byte is accepted, with mem_addr = BASE_ADDR + index, modulo 2^ADDR_W (wrap-around).
REQ-021 After the Nth word is written, the FSM SHALL go to CHK (CHECKSUM_EN defined) or DONE.
REQ-022 in_ready SHALL be high only in HDR, LOAD and CHK, and SHALL be low in the cycle mem_we is high, so that accept and write never coincide.
REQ-023 DONE: cpu_run SHALL be 1 and busy 0; the FSM SHALL stay in DONE until rst.
REQ-024 ERR: error SHALL be 1, cpu_run 0 and in_ready 0; the FSM SHALL stay in ERR until rst.
REQ-025 busy SHALL be 1 exactly in HDR, LOAD and CHK.
REQ-026 Gaps in in_valid SHALL stall assembly without loss; partial bytes are held.

Reset
REQ-027 On rst, the FSM SHALL go to IDLE and all outputs SHALL be 0; words_loaded, the byte counter and the partial word SHALL be cleared.
REQ-028 rst mid-load SHALL discard the partial word; words already written remain in memory; cpu_run SHALL stay 0.
REQ-029 rst SHALL take priority over start and in_valid in the same cycle.

Configuration
REQ-030 With CHECKSUM_EN defined, CHK SHALL accept one trailer word and compare it with the XOR of all N loaded words: equal -> DONE, mismatch -> ERR.
REQ-031 Without CHECKSUM_EN, the CHK state and the XOR accumulator SHALL be absent, and LOAD SHALL go directly to DONE.

Structure
REQ-032 The loader state enum, the MIPS opcode constants and the type codes (RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT) SHALL reside in shared package mips_pkg.
REQ-033 Byte-to-word assembly SHALL be a sub-module mips_byte_packer: 8-bit in, 32-bit out, with a word_valid pulse.

Verification
REQ-034 Header N=2, words 32'h2801000A and 32'hFC000000 -> mem_we at addr 0 and 1 with those data; words_loaded=2; cpu_run=1.
REQ-035 Header N=0 -> error=1 after the 4th header byte; no mem_we pulse; in_ready=0.
REQ-036 BASE_ADDR=1022, N=3 -> writes to addresses 1022, 1023, 0.
REQ-037 in_valid toggled every other cycle, N=1, word 32'h12345678 -> a single write of 32'h12345678.
REQ-038 rst asserted after 6 bytes of N=4 -> IDLE, busy=0, cpu_run=0; a subsequent start and full load completes correctly.
REQ-039 CHECKSUM_EN, N=2, words 32'hF0F0F0F0 and 32'h0F0F0F0F: trailer 32'hFFFFFFFF -> cpu_run=1; trailer 0 -> error=1.
